noc_vc_split: RTL

//  - Router input side: splits one shared flit link into CHANNELS per-VC FIFOs; VC selected by which in_valid bit is set.
//  - Returns per-VC ready and early-warning vc_ready upstream; presents CHANNELS independent valid/ready flit streams downstream.
//  - Counterpart of the VC merge stage at the far end of the same link.

---
 rtl/noc_vc_split_pkg.sv | 37 +++
 rtl/noc_vc_split_if.sv | 39 +++
 rtl/noc_vc_split_fifo.sv | 77 +++++++
 rtl/noc_vc_split.sv | 124 ++++++++++++
 4 files changed

// File: rtl/noc_vc_split_pkg.sv
// ---------------------------------------------------------------------------
// noc_vc_split_pkg
// Shared NoC parameters and types for the VC split stage.
//   Noc_VC_Channel     default number of virtual channels
//   Noc_Data_Width     default flit width
//   Noc_VC_Fifo_Depth  default entries per VC FIFO
//   NOC_TYPE_W         width of the flit-type field, held in the flit MSBs
//   noc_flit_type_e    flit type encoding
//   noc_frame_state_e  per-VC framing checker state
//   sat_inc8           8-bit saturating increment
// ---------------------------------------------------------------------------
package noc_vc_split_pkg;

    localparam int Noc_VC_Channel    = 4;
    localparam int Noc_Data_Width    = 16;
    localparam int Noc_VC_Fifo_Depth = 8;

    // Flit type lives in in_flit[DATA_WIDTH-1 -: NOC_TYPE_W]
    localparam int NOC_TYPE_W = 2;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } noc_flit_type_e;

    typedef enum logic {
        FRAME_IDLE   = 1'b0,
        FRAME_IN_PKT = 1'b1
    } noc_frame_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/noc_vc_split_if.sv
// ---------------------------------------------------------------------------
// noc_vc_split_if
// Link bundle around the VC split stage.
//   in_valid  [CHANNELS]             per-VC valid from upstream (one-hot)
//   in_flit   [DATA_WIDTH]           shared upstream flit bus
//   in_ready  [CHANNELS]             per-VC FIFO not full
//   vc_ready  [CHANNELS]             per-VC early warning (below threshold)
//   out_valid [CHANNELS]             per-VC head valid
//   out_flit  [CHANNELS*DATA_WIDTH]  per-VC head flit, VC i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_ready [CHANNELS]             per-VC downstream pop
// master: the environment (upstream sender plus downstream consumer).
// slave : the split stage itself.
// ---------------------------------------------------------------------------
interface noc_vc_split_if
    import noc_vc_split_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int DATA_WIDTH = Noc_Data_Width
) ();

    logic [CHANNELS-1:0]            in_valid;
    logic [DATA_WIDTH-1:0]          in_flit;
    logic [CHANNELS-1:0]            in_ready;
    logic [CHANNELS-1:0]            vc_ready;
    logic [CHANNELS-1:0]            out_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] out_flit;
    logic [CHANNELS-1:0]            out_ready;

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, vc_ready, out_valid, out_flit
    );

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, vc_ready, out_valid, out_flit
    );

endinterface

// File: rtl/noc_vc_split_fifo.sv
// ---------------------------------------------------------------------------
// noc_vc_split_fifo
// Single-VC synchronous FIFO with registered storage (no fall-through).
//   clk, rst     clock, synchronous active-high reset
//   clear        synchronous flush
//   push, pop    write / read requests (internally gated by full / valid)
//   wr_data      flit to store
//   rd_data      head flit, stable until popped
//   valid        FIFO not empty
//   full         count == DEPTH
//   below_thr    count < THRESHOLD
// DEPTH need not be a power of two; pointers wrap explicitly.
// ---------------------------------------------------------------------------
module noc_vc_split_fifo
    import noc_vc_split_pkg::*;
#(
    parameter int DATA_WIDTH = Noc_Data_Width,
    parameter int DEPTH      = Noc_VC_Fifo_Depth,
    parameter int THRESHOLD  = Noc_VC_Fifo_Depth - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic                  full,
    output logic                  below_thr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // A full FIFO refuses a push even if it is being popped in the same cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= wr_data;
    end

    assign rd_data   = mem[rd_ptr];
    assign valid     = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign below_thr = (count < CNT_W'(THRESHOLD));

endmodule

// File: rtl/noc_vc_split.sv
// ---------------------------------------------------------------------------
// noc_vc_split
// Router input stage: demultiplexes one shared flit link into CHANNELS
// independent per-VC FIFOs, selected by the one-hot in_valid.
//   noc_clk, noc_rst  clock, synchronous active-high reset
//   i_clear           synchronous flush of all VC FIFOs (errors kept)
//   link (slave)      in_valid/in_flit/in_ready/vc_ready upstream,
//                     out_valid/out_flit/out_ready downstream
//   o_err             sticky per-VC framing error
//   o_err_count       saturating framing error count
// Optional: define NOC_VC_SPLIT_CHECK_EN to enable per-VC framing checkers;
// otherwise o_err and o_err_count are tied to zero.
// ---------------------------------------------------------------------------
module noc_vc_split
    import noc_vc_split_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int DATA_WIDTH = Noc_Data_Width,
    parameter int DEPTH      = Noc_VC_Fifo_Depth,
    parameter int THRESHOLD  = Noc_VC_Fifo_Depth - 2
) (
    input  logic                noc_clk,
    input  logic                noc_rst,
    input  logic                i_clear,
    noc_vc_split_if.slave       link,
    output logic [CHANNELS-1:0] o_err,
    output logic [7:0]          o_err_count
);

    logic                           one_hot;
    logic [CHANNELS-1:0]            push;
    logic [CHANNELS-1:0]            pop;
    logic [CHANNELS-1:0]            full;
    logic [CHANNELS-1:0]            valid;
    logic [CHANNELS-1:0]            below;
    logic [DATA_WIDTH-1:0]          head [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] head_bus;

    // A multi-hot in_valid is malformed; nothing is written in that cycle
    assign one_hot = $onehot(link.in_valid);
    assign push    = link.in_valid & ~full & {CHANNELS{one_hot}};
    assign pop     = valid & link.out_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
        noc_vc_split_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .THRESHOLD  (THRESHOLD)
        ) u_fifo (
            .clk       (noc_clk),
            .rst       (noc_rst),
            .clear     (i_clear),
            .push      (push[i]),
            .pop       (pop[i]),
            .wr_data   (link.in_flit),
            .rd_data   (head[i]),
            .valid     (valid[i]),
            .full      (full[i]),
            .below_thr (below[i])
        );
        assign head_bus[i*DATA_WIDTH +: DATA_WIDTH] = head[i];
    end

    // Ready flags come only from registered counts, never from out_ready
    assign link.in_ready  = ~full;
    assign link.vc_ready  = below;
    assign link.out_valid = valid;
    assign link.out_flit  = head_bus;

`ifdef NOC_VC_SPLIT_CHECK_EN
    noc_frame_state_e    frame_state [CHANNELS];
    noc_flit_type_e      flit_type;
    logic                multi_hot;
    logic [CHANNELS-1:0] frame_err;

    assign flit_type = noc_flit_type_e'(link.in_flit[DATA_WIDTH-1 -: NOC_TYPE_W]);
    assign multi_hot = (link.in_valid != '0) && !one_hot;

    // Only flits actually accepted into a FIFO are framing-checked
    always_comb begin
        frame_err = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                if (frame_state[i] == FRAME_IDLE)
                    frame_err[i] = (flit_type == FLIT_BODY) || (flit_type == FLIT_TAIL);
                else
                    frame_err[i] = (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
            end
        end
    end

    // Framing FSMs plus error flags; a flush discards partial packets, so
    // the FSMs return to IDLE but the error history survives
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int i = 0; i < CHANNELS; i++) frame_state[i] <= FRAME_IDLE;
            o_err       <= '0;
            o_err_count <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < CHANNELS; i++) frame_state[i] <= FRAME_IDLE;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) begin
                    case (frame_state[i])
                        FRAME_IDLE:
                            if (flit_type == FLIT_HEAD) frame_state[i] <= FRAME_IN_PKT;
                        FRAME_IN_PKT:
                            if (flit_type == FLIT_TAIL) frame_state[i] <= FRAME_IDLE;
                        default:
                            frame_state[i] <= FRAME_IDLE;
                    endcase
                end
            end
            o_err <= o_err | frame_err;
            // At most one error event per cycle: one-hot and multi-hot exclude each other
            if (multi_hot || (frame_err != '0)) o_err_count <= sat_inc8(o_err_count);
        end
    end
`else
    assign o_err       = '0;
    assign o_err_count = '0;
`endif

endmodule
